regfile_wb: RTL
===============

# regfile_wb

Write-side front end for the 32x32 register file: merges single-cycle ALU results and handshaked load responses onto the register file's single write port (`we`/`wa`/`wdata`). Load responses are buffered in a small FIFO so ALU writes never stall. A pending-register scoreboard, set at load issue and cleared at load writeback, is exported to the hazard logic.

## Interface
- `DEPTH`, 2: load-response FIFO entries; power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result valid this cycle; always accepted, no ready signal.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `ld_valid`  in  1  load response valid.
- `ld_ready`  out  1  load response accepted when `ld_valid && ld_ready`.
- `ld_rd`  in  5  load destination register.
- `ld_data`  in  32  load data.
- `iss_valid`  in  1  load issued this cycle; marks `iss_rd` pending.
- `iss_rd`  in  5  destination register of the issued load.
- `we`  out  1  register file write enable; registered.
- `wa`  out  5  register file write address; registered.
- `wdata`  out  32  register file write data; registered.
- `pending`  out  32  scoreboard; bit r = 1 means a load to xr is outstanding; bit 0 is always 0.
- `sb_err`  out  1  sticky flag: a load response was accepted for a register that was not pending.

## Operation
- Reset (`reset` = 0): `we` = 0, `wa` = 0, `wdata` = 0, `pending` = 0, `sb_err` = 0, FIFO empty, count = 0, `ld_ready` forced to 0. Reset takes effect immediately (asynchronously), including mid-operation; all buffered loads are discarded.
- `ld_ready` = `reset` && (count < `DEPTH`). It is combinational from count only and does not depend on `ld_valid` or on a same-cycle pop.
- Push: when `ld_valid && ld_ready`, {`ld_rd`, `ld_data`} is written at the FIFO tail at the clock edge.
- Port arbitration for each cycle N:
  - ALU write: an ALU write is requested when `alu_valid` && `alu_rd` != 0. It has priority.
  - Load pop: when no ALU write is requested and the FIFO is non-empty at the start of cycle N, the head entry is popped.
  - Otherwise no write.
- Output register: at the end of cycle N, `we`/`wa`/`wdata` load the winning source. If there is no winner, `we` = 0 and `wa`/`wdata` hold their previous values.
- x0 writes: `alu_valid` with `alu_rd` = 0 is dropped and does not consume the port. A load to x0 is pushed and popped normally, but its pop drives `we` = 0.
- FIFO order: strict FIFO order. Simultaneous push and pop is allowed at any count below `DEPTH`; the count is unchanged.
- Pointers: wrap modulo `DEPTH`. The count is log2(`DEPTH`)+1 bits wide.
- Scoreboard set: at the edge, if `iss_valid` && `iss_rd` != 0, then `pending[iss_rd]` is set to 1.
- Scoreboard clear: at the edge where a load pop is registered, `pending[head_rd]` is cleared to 0.
- Set and clear of the same register in the same cycle: set wins.
- ALU writes never modify `pending`.
- `sb_err`: set at the edge of any accepted push whose `ld_rd` != 0 and whose `pending[ld_rd]` = 0 at that moment. It stays set until reset.

## Timing
- ALU path: `alu_valid` in cycle N gives `we` = 1 in cycle N+1. The register file is updated at the end of N+1.
- Load path, FIFO empty and port free: accepted in cycle N, popped in N+1, `we` = 1 in N+2.
- `pending` bit fall: the bit falls in the same cycle that `we` rises for that load.
- Load starvation: a continuous stream of ALU writes with rd != 0 starves the FIFO indefinitely. Once the FIFO is full, `ld_ready` = 0 and backpressure holds the upstream source.
- Throughput: one register file write per cycle maximum.

## Test plan
- **ALU only:** `alu_valid` = 1, rd = 5, data = 0xDEADBEEF in cycle 1 -> `we` = 1, `wa` = 5, `wdata` = 0xDEADBEEF in cycle 2. With `alu_rd` = 0 -> `we` stays 0.
- **Load with scoreboard:** issue x7 in cycle 1 (`pending[7]` = 1 from cycle 2); response ld_rd = 7, data = 0x1234 accepted in cycle 4 -> `we` = 1, `wa` = 7 in cycle 6, with `pending[7]` = 0 in the same cycle; `sb_err` stays 0.
- **Contention and full:** `DEPTH` = 2, ALU valid rd = 1 every cycle, three load responses offered back-to-back -> two accepted, `ld_ready` = 0 afterwards, no load writes. Drop `alu_valid` -> loads are written in order on consecutive cycles, then `ld_ready` returns to 1.
- **Same-cycle set/clear:** pop of x3 coincides with `iss_valid` for rd = 3 -> `pending[3]` remains 1.
- **Orphan response:** response for x9 with `pending[9]` = 0 -> `sb_err` = 1, and it remains 1 until `reset` is asserted.
- **Reset mid-operation:** assert `reset` = 0 with 2 FIFO entries and `pending` = 0x00000088 -> immediately `we` = 0, `pending` = 0, `ld_ready` = 0. After release, `ld_ready` = 1 and no stale writes occur.

Source files
------------

// File: rtl/regfile_wb.sv
// Write-side front end of the 32x32 register file: merges ALU results and buffered load
// responses onto the single write port and tracks outstanding loads in a pending scoreboard.
module regfile_wb #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wdata,
  output logic [31:0] pending,
  output logic        sb_err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [PW-1:0] PtrOne   = PW'(1);
  localparam logic [CW-1:0] CntOne   = CW'(1);

  // Load-response FIFO storage; contents need no reset since count gates every read.
  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic        we_q, we_d;
  logic [4:0]  wa_q, wa_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pending_q, pending_d;
  logic        sb_err_q, sb_err_d;

  logic        alu_req;
  logic        push;
  logic        pop;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign ld_ready  = reset && (count_q < DepthCnt);
  assign alu_req   = alu_valid && (alu_rd != 5'd0);
  assign push      = ld_valid && ld_ready;
  // ALU owns the port whenever it has a real write; loads only drain in idle slots.
  assign pop       = !alu_req && (count_q != '0);
  assign head_rd   = rd_mem[head_q];
  assign head_data = data_mem[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      tail_d = tail_q + PtrOne;
    end
    if (pop) begin
      head_d = head_q + PtrOne;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    we_d    = 1'b0;
    wa_d    = wa_q;
    wdata_d = wdata_q;
    if (alu_req) begin
      we_d    = 1'b1;
      wa_d    = alu_rd;
      wdata_d = alu_data;
    end else if (pop && (head_rd != 5'd0)) begin
      we_d    = 1'b1;
      wa_d    = head_rd;
      wdata_d = head_data;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[head_rd] = 1'b0;
    end
    // A new issue to the register being retired keeps it pending.
    if (iss_valid && (iss_rd != 5'd0)) begin
      pending_d[iss_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    sb_err_d = sb_err_q;
    if (push && (ld_rd != 5'd0) && !pending_q[ld_rd]) begin
      sb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_q]   <= ld_rd;
      data_mem[tail_q] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      we_q      <= we_d;
      wa_q      <= wa_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign we      = we_q;
  assign wa      = wa_q;
  assign wdata   = wdata_q;
  assign pending = pending_q;
  assign sb_err  = sb_err_q;

endmodule
